seg_rx_decode: RTL and testbench

- Receive side of the seven-segment display path: samples a 7-bit segment bus, debounces it, decodes it back to a 4-bit hex value, and flags undecodable patterns.
- Checks each accepted value against the state-counter stepping rules (forward and alternate sequence) and recovers the direction input that produced the step.
- Sits between a segment-bus tap and a self-check / status LED block; sampling is paced by a divided-clock tick.

---
 rtl/seg_rx_decode.sv | 219 +++++++++++++++++++++
 tb/tb_seg_rx_decode.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_rx_decode.sv
// Seven-segment receive path: debounces a sampled segment bus, decodes it to a hex digit, and checks
// each step against the mod-6 forward/alternate counter sequences. SEG_ACTIVE_HIGH_EN selects an active-high bus.
`timescale 1ns/1ps
module seg_rx_decode #(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned MODULUS    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [6:0] seg_in,
  output logic [3:0] value,
  output logic       valid,
  output logic       new_pulse,
  output logic       invalid,
  output logic [1:0] step_code,
  output logic       in_est,
  output logic [7:0] err_count
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned VAL_W = 4;
  localparam int unsigned ERR_W = 8;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    SETTLING = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam logic [1:0] STEP_NONE = 2'b00;
  localparam logic [1:0] STEP_FWD  = 2'b01;
  localparam logic [1:0] STEP_ALT  = 2'b10;
  localparam logic [1:0] STEP_ILL  = 2'b11;

  // Internal segment view is always active-low.
  logic [SEG_W-1:0] seg;
`ifdef SEG_ACTIVE_HIGH_EN
  assign seg = ~seg_in;
`else
  assign seg = seg_in;
`endif

  // {ok, digit} for an active-low pattern.
  function automatic logic [VAL_W:0] decode(input logic [SEG_W-1:0] s);
    logic [VAL_W:0] r;
    r = '0;
    unique case (s)
      7'h40: r = {1'b1, 4'h0};
      7'h79: r = {1'b1, 4'h1};
      7'h24: r = {1'b1, 4'h2};
      7'h30: r = {1'b1, 4'h3};
      7'h19: r = {1'b1, 4'h4};
      7'h12: r = {1'b1, 4'h5};
      7'h02: r = {1'b1, 4'h6};
      7'h78: r = {1'b1, 4'h7};
      7'h00: r = {1'b1, 4'h8};
      7'h10: r = {1'b1, 4'h9};
      7'h08: r = {1'b1, 4'hA};
      7'h03: r = {1'b1, 4'hB};
      7'h46: r = {1'b1, 4'hC};
      7'h21: r = {1'b1, 4'hD};
      7'h06: r = {1'b1, 4'hE};
      7'h0E: r = {1'b1, 4'hF};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Successor in the alternate sequence 0-3-1-5-4-2-0; F marks "no successor".
  function automatic logic [VAL_W-1:0] alt_next(input logic [VAL_W-1:0] p);
    logic [VAL_W-1:0] r;
    r = 4'hF;
    unique case (p)
      4'h0: r = 4'h3;
      4'h3: r = 4'h1;
      4'h1: r = 4'h5;
      4'h5: r = 4'h4;
      4'h4: r = 4'h2;
      4'h2: r = 4'h0;
      default: r = 4'hF;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [SEG_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             new_pulse_q, new_pulse_d;
  logic             invalid_q, invalid_d;
  logic [1:0]       step_code_q, step_code_d;
  logic             in_est_q, in_est_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic             accept;
  logic             err_inc;
  logic [VAL_W:0]   dec;
  logic [VAL_W-1:0] fwd_next;
  logic             in_range;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      cand_q      <= 7'h7F;
      cnt_q       <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      new_pulse_q <= 1'b0;
      invalid_q   <= 1'b0;
      step_code_q <= STEP_NONE;
      in_est_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      new_pulse_q <= new_pulse_d;
      invalid_q   <= invalid_d;
      step_code_q <= step_code_d;
      in_est_q    <= in_est_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    value_d     = value_q;
    valid_d     = valid_q;
    new_pulse_d = 1'b0;
    invalid_d   = invalid_q;
    step_code_d = step_code_q;
    in_est_d    = in_est_q;
    accept      = 1'b0;
    err_inc     = 1'b0;
    dec         = '0;
    fwd_next    = '0;
    in_range    = 1'b0;

    // Debounce: a pattern must match for STABLE_CNT consecutive samples.
    if (sample_en) begin
      unique case (state_q)
        EMPTY: begin
          cand_d  = seg;
          cnt_d   = CNT_W'(1);
          state_d = SETTLING;
        end
        SETTLING: begin
          if (seg == cand_q) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cand_d = seg;
            cnt_d  = CNT_W'(1);
          end
        end
        LOCKED: begin
          if (seg != cand_q) begin
            cand_d  = seg;
            cnt_d   = CNT_W'(1);
            state_d = SETTLING;
          end
        end
        default: state_d = EMPTY;
      endcase
      if (state_d == SETTLING && cnt_d >= CNT_W'(STABLE_CNT)) begin
        accept  = 1'b1;
        state_d = LOCKED;
      end
    end

    dec      = decode(cand_d);
    fwd_next = (value_q == VAL_W'(MODULUS - 1)) ? '0 : value_q + VAL_W'(1);
    in_range = (value_q < VAL_W'(MODULUS)) && (dec[VAL_W-1:0] < VAL_W'(MODULUS));

    if (accept) begin
      if (dec[VAL_W]) begin
        value_d     = dec[VAL_W-1:0];
        valid_d     = 1'b1;
        invalid_d   = 1'b0;
        new_pulse_d = 1'b1;
        step_code_d = STEP_NONE;
        if (valid_q) begin
          if (in_range && dec[VAL_W-1:0] == fwd_next) begin
            step_code_d = STEP_FWD;
            in_est_d    = 1'b1;
          end else if (in_range && dec[VAL_W-1:0] == alt_next(value_q)) begin
            step_code_d = STEP_ALT;
            in_est_d    = 1'b0;
          end else begin
            step_code_d = STEP_ILL;
            err_inc     = 1'b1;
          end
        end
      end else begin
        valid_d     = 1'b0;
        invalid_d   = 1'b1;
        step_code_d = STEP_NONE;
        err_inc     = 1'b1;
      end
    end

    err_count_d = (err_inc && err_count_q != '1) ? err_count_q + ERR_W'(1) : err_count_q;
  end

  assign value     = value_q;
  assign valid     = valid_q;
  assign new_pulse = new_pulse_q;
  assign invalid   = invalid_q;
  assign step_code = step_code_q;
  assign in_est    = in_est_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_seg_rx_decode.sv
// Scoreboard bench for seg_rx_decode: stimulus pushes expected accept results, a monitor pops them on each output event.
`timescale 1ns/1ps
module tb_seg_rx_decode;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_en = 1'b0;
  logic [6:0] seg_in = 7'h7F;
  logic [3:0] value;
  logic       valid;
  logic       new_pulse;
  logic       invalid;
  logic [1:0] step_code;
  logic       in_est;
  logic [7:0] err_count;

  typedef struct packed {
    logic [3:0] val;
    logic       vld;
    logic       inv;
    logic [1:0] step;
    logic       ie;
    logic [7:0] err;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  seg_rx_decode dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .seg_in    (seg_in),
    .value     (value),
    .valid     (valid),
    .new_pulse (new_pulse),
    .invalid   (invalid),
    .step_code (step_code),
    .in_est    (in_est),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [3:0] v, input logic vl, input logic iv,
                      input logic [1:0] st, input logic ie, input logic [7:0] e);
    exp_t x;
    x.val = v; x.vld = vl; x.inv = iv; x.step = st; x.ie = ie; x.err = e;
    expq.push_back(x);
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    repeat (n) begin
      @(negedge clk);
      seg_in    = p;
      sample_en = 1'b1;
      @(negedge clk);
      sample_en = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Event = new_pulse, or a change of err_count/invalid (invalid accepts have no pulse).
  task automatic monitor();
    logic [7:0] prev_err;
    logic       prev_inv;
    logic       prev_np;
    exp_t       e;
    prev_err = '0; prev_inv = 1'b0; prev_np = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_err = '0; prev_inv = 1'b0; prev_np = 1'b0;
      end else begin
        if (new_pulse) chk("pulse_width", 32'(prev_np), 32'd0);
        if (new_pulse || err_count != prev_err || invalid != prev_inv) begin
          if (expq.size() == 0) begin
            chk("unexpected_accept", {value, valid, invalid, step_code, in_est, err_count, new_pulse}, 32'h0);
          end else begin
            e = expq.pop_front();
            chk("accept", {value, valid, invalid, step_code, in_est, err_count, new_pulse},
                {e.val, e.vld, e.inv, e.step, e.ie, e.err, e.vld});
          end
        end
        prev_err = err_count; prev_inv = invalid; prev_np = new_pulse;
      end
    end
  endtask

  initial begin
    fork
      monitor();
      begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
      begin
        do_reset();
        #1;
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pulse", 32'(new_pulse), 32'd0);
        chk("rst_invalid", 32'(invalid), 32'd0);
        chk("rst_step", 32'(step_code), 32'd0);
        chk("rst_in_est", 32'(in_est), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);

        // Forward sequence 0..5,0
        push(4'h0, 1, 0, 2'b00, 0, 8'd0); hold(7'h40, 4);
        push(4'h1, 1, 0, 2'b01, 1, 8'd0); hold(7'h79, 4);
        push(4'h2, 1, 0, 2'b01, 1, 8'd0); hold(7'h24, 4);
        push(4'h3, 1, 0, 2'b01, 1, 8'd0); hold(7'h30, 4);
        push(4'h4, 1, 0, 2'b01, 1, 8'd0); hold(7'h19, 4);
        push(4'h5, 1, 0, 2'b01, 1, 8'd0); hold(7'h12, 4);
        push(4'h0, 1, 0, 2'b01, 1, 8'd0); hold(7'h40, 4);

        // Alternate sequence from 0 (40 already locked, so no re-accept)
        hold(7'h40, 4);
        push(4'h3, 1, 0, 2'b10, 0, 8'd0); hold(7'h30, 4);
        push(4'h1, 1, 0, 2'b10, 0, 8'd0); hold(7'h79, 4);
        push(4'h5, 1, 0, 2'b10, 0, 8'd0); hold(7'h12, 4);
        push(4'h4, 1, 0, 2'b10, 0, 8'd0); hold(7'h19, 4);
        push(4'h2, 1, 0, 2'b10, 0, 8'd0); hold(7'h24, 4);
        push(4'h0, 1, 0, 2'b10, 0, 8'd0); hold(7'h40, 4);

        // Invalid accept clears history
        do_reset();
        push(4'h0, 1, 0, 2'b00, 0, 8'd0); hold(7'h40, 4);
        push(4'h0, 0, 1, 2'b00, 0, 8'd1); hold(7'h55, 4);
        push(4'h1, 1, 0, 2'b00, 0, 8'd1); hold(7'h79, 4);

        // Interrupted run, then illegal jump 0->2
        do_reset();
        push(4'h0, 1, 0, 2'b00, 0, 8'd0); hold(7'h40, 4);
        hold(7'h24, 3);
        hold(7'h40, 1);
        push(4'h2, 1, 0, 2'b11, 0, 8'd1); hold(7'h24, 4);

        // Reset in the middle of a settling run
        do_reset();
        hold(7'h79, 2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_outputs", {value, valid, new_pulse, invalid, step_code, in_est, err_count}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        hold(7'h79, 3);
        chk("midrst_no_early", 32'(valid), 32'd0);
        push(4'h1, 1, 0, 2'b00, 0, 8'd0); hold(7'h79, 1);

        // err_count saturation, blank counts as invalid
        do_reset();
        for (int i = 0; i < 255; i++) begin
          push(4'h0, 0, 1, 2'b00, 0, 8'(i + 1));
          hold((i % 2 == 1) ? 7'h55 : 7'h7F, 4);
        end
        hold(7'h55, 4);
        chk("sat_err", 32'(err_count), 32'd255);
        chk("sat_invalid", 32'(invalid), 32'd1);
        push(4'h0, 1, 0, 2'b00, 0, 8'd255); hold(7'h40, 4);
        push(4'h4, 1, 0, 2'b11, 0, 8'd255); hold(7'h19, 4);

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(expq.size()), 32'd0);
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
